// File: rtl/dmem_responder.sv
// ============================================================================
// Module   : dmem_responder
// Brief    : Multi-cycle data-memory target for the MEM stage; stalls the
//            pipeline for LATENCY cycles per access and owns the word array.
//            Optional one-entry posted write buffer: DMEM_WRITE_BUFFER_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_responder #(
    parameter int ADDR_W  = 5,
    parameter int LATENCY = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              DMemR,
    input  logic              DMemW,
    input  logic [ADDR_W-1:0] DataAdr,
    input  logic [31:0]       DataIn,
    output logic [31:0]       DataOut,
    output logic              Stall,
    output logic              Ready
);

    localparam int         DEPTH   = 2**ADDR_W;
    localparam logic [3:0] c_latM1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_nextState;

    logic [31:0]       r_mem [DEPTH];
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_data;
    logic              r_isWrite;
    logic [3:0]        r_count;

    logic              w_req;
    logic              w_start;
    logic              w_loadOut;
    logic [ADDR_W-1:0] w_rdAdr;
    logic              w_memWe;
    logic [ADDR_W-1:0] w_memAdr;
    logic [31:0]       w_memData;
    logic              w_bufBusy;
    logic              w_post;

    assign w_req = DMemR | DMemW;

`ifdef DMEM_WRITE_BUFFER_EN
    localparam logic [3:0] c_lat = 4'(LATENCY);

    logic              r_bufValid;
    logic [ADDR_W-1:0] r_bufAddr;
    logic [31:0]       r_bufData;
    logic [3:0]        r_bufCount;
    logic              w_bufDrain;

    assign w_bufBusy  = r_bufValid;
    assign w_post     = DMemW & ~r_bufValid;
    assign w_bufDrain = r_bufValid & (r_bufCount == 4'd1);

    // Posted write retires on the edge ending its LATENCY-th cycle in the buffer.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_bufValid <= 1'b0;
            r_bufAddr  <= '0;
            r_bufData  <= '0;
            r_bufCount <= 4'd0;
        end else if (r_state == IDLE && w_post) begin
            r_bufValid <= 1'b1;
            r_bufAddr  <= DataAdr;
            r_bufData  <= DataIn;
            r_bufCount <= c_lat;
        end else if (r_bufValid) begin
            r_bufCount <= r_bufCount - 4'd1;
            if (r_bufCount == 4'd1) begin
                r_bufValid <= 1'b0;
            end
        end
    end

    assign w_memWe   = ~Reset & (w_bufDrain | ((r_state == DONE) & r_isWrite));
    assign w_memAdr  = w_bufDrain ? r_bufAddr : r_addr;
    assign w_memData = w_bufDrain ? r_bufData : r_data;
`else
    assign w_bufBusy = 1'b0;
    assign w_post    = 1'b0;
    assign w_memWe   = ~Reset & (r_state == DONE) & r_isWrite;
    assign w_memAdr  = r_addr;
    assign w_memData = r_data;
`endif

    always_comb begin
        w_nextState = r_state;
        Stall       = 1'b0;
        Ready       = 1'b0;
        w_start     = 1'b0;
        w_loadOut   = 1'b0;
        w_rdAdr     = r_addr;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    if (w_bufBusy) begin
                        Stall = 1'b1;
                    end else if (w_post) begin
                        Ready = 1'b1;
                    end else begin
                        Stall       = 1'b1;
                        w_start     = 1'b1;
                        w_nextState = (LATENCY >= 2) ? WAIT : DONE;
                        // Single-cycle latency: read data lands on this same edge.
                        if (LATENCY == 1 && !DMemW) begin
                            w_loadOut = 1'b1;
                            w_rdAdr   = DataAdr;
                        end
                    end
                end
            end
            WAIT: begin
                Stall = 1'b1;
                if (r_count == 4'd1) begin
                    w_nextState = DONE;
                    w_loadOut   = ~r_isWrite;
                end
            end
            DONE: begin
                Ready       = 1'b1;
                w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
        if (Reset) begin
            Stall = 1'b0;
            Ready = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state   <= IDLE;
            DataOut   <= '0;
            r_addr    <= '0;
            r_data    <= '0;
            r_isWrite <= 1'b0;
            r_count   <= 4'd0;
        end else begin
            r_state <= w_nextState;
            if (w_start) begin
                r_addr    <= DataAdr;
                r_data    <= DataIn;
                r_isWrite <= DMemW;
                r_count   <= c_latM1;
            end else if (r_state == WAIT) begin
                r_count <= r_count - 4'd1;
            end
            if (w_loadOut) begin
                DataOut <= r_mem[w_rdAdr];
            end
        end
    end

    // Storage is deliberately outside the reset domain.
    always_ff @(posedge Clk) begin
        if (w_memWe) begin
            r_mem[w_memAdr] <= w_memData;
        end
    end

endmodule

`default_nettype wire

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Multi-cycle data-memory responder: the target end of the MEM-stage data-memory port (DMemR/DMemW/DataAdr/DataIn -> DataOut) that the pipeline drives.
- Replaces the zero-wait data memory.
- Models a LATENCY-cycle array access.
- Raises Stall so the pipeline freezes all stages until the access completes.
- Owns the word-addressed storage array.

Parameters:
ADDR_W, 5, word-address width; array depth = 2**ADDR_W 32-bit words
LATENCY, 2, access latency in cycles; legal range 1..15; equals the number of stall cycles per access

Ports:
Clk  input  1  clock, all state on rising edge
Reset  input  1  synchronous, active-high reset
DMemR  input  1  read request, MEM stage
DMemW  input  1  write request, MEM stage
DataAdr  input  ADDR_W  word address
DataIn  input  32  write data
DataOut  output  32  read data, registered
Stall  output  1  access in progress; pipeline holds all stage registers
Ready  output  1  one-cycle pulse: access completes this cycle

Behaviour:
- One clock (Clk). Reset is synchronous and active-high.
- Reset: state=IDLE, DataOut=0, Ready=0, Stall forced 0 while Reset=1, counter=0, latches cleared. Array contents are NOT altered by Reset.
- FSM states: IDLE, WAIT, DONE. Request req = DMemR|DMemW.
- IDLE:
  - With req=1: Stall=1 combinationally in the same cycle.
  - Latch addr, data, op (W has priority if DMemR&DMemW: write performed, read ignored, DataOut unchanged).
  - Counter loaded with LATENCY-1.
  - Next state is WAIT if LATENCY>=2, else DONE.
  - With req=0: Stall=0, stay IDLE.
- WAIT: Stall=1. Counter decrements each cycle. At counter==1, next state is DONE.
- DONE: Stall=0, Ready=1.
  - Read: DataOut holds array[latched addr]; the value is loaded on the edge entering DONE.
  - Write: array[latched addr] <= latched data on the edge leaving DONE.
  - Next state is always IDLE; the request still present in DONE is NOT retriggered.
  - A request in the following IDLE cycle starts a new access.
- Timing: request first seen in cycle t -> Stall=1 in cycles t..t+LATENCY-1, Ready=1 in cycle t+LATENCY. Total stall cycles = LATENCY.
- DataOut holds its value until the next completed read. Writes never change DataOut.
- Inputs changing while Stall=1 (protocol violation) are ignored; the latched values are used.
- Reset in WAIT or DONE: the access is aborted, a pending write is not committed, next cycle is IDLE with Stall=0.
- Back-to-back accesses: at least one IDLE cycle between DONE and the next WAIT, i.e. LATENCY+1 cycles per access.
- Address wraps naturally within ADDR_W; no range checking.

Optional Feature:
DMEM_WRITE_BUFFER_EN
- Defined: one-entry posted write buffer.
  - Write in IDLE with buffer empty: Stall=0, Ready=1 in the same cycle; addr/data captured into the buffer.
  - The buffer drains to the array after LATENCY cycles in the background, with the write occurring on the edge ending the LATENCY-th cycle.
  - A write or read arriving while the buffer is occupied: Stall=1 until the drain completes, then normal handling. A read therefore always observes the drained data.
  - Reset discards buffer contents.
- Undefined: writes follow the base FSM exactly. No buffer logic is present.

Test Plan:
- LATENCY=2, preload array[3]=0xDEADBEEF, DMemR=1 Adr=3 at cycle 0 -> Stall=1 cycles 0-1; Ready=1 and DataOut=0xDEADBEEF at cycle 2; Stall=0 at cycle 2.
- LATENCY=3, write Adr=7 Data=0x12345678 then read Adr=7 -> write Ready at cycle 3, read issued at cycle 4, Ready at cycle 7 with DataOut=0x12345678.
- DMemR=DMemW=1, Adr=1, Data=0xA5A5A5A5, prior DataOut=0x0 -> write commits (later read returns 0xA5A5A5A5); DataOut stays 0x0 at Ready.
- During WAIT, change DataAdr 4->9 and DataIn -> write lands at array[4] only; array[9] unchanged.
- Write Adr=2 Data=0x55 with Reset asserted in WAIT -> next cycle IDLE, Stall=0, Ready never pulses, read of array[2] returns the old value.
- DMEM_WRITE_BUFFER_EN, LATENCY=2: two writes in consecutive cycles -> first Stall=0/Ready=1 at cycle 0; second stalls until the drain completes; both values are read back correctly.
